// File: rtl/rotor_slice_timer.sv
// Angular timing generator: measures Hall magnet intervals and splits each
// segment into equal slices with a fractional phase accumulator.
module rotor_slice_timer #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int NUM_MAG     = 32,
  parameter int NUM_SLICES  = 256,
  parameter int FRAC_BITS   = 8,
  parameter int DEBOUNCE    = 16,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                             clk,
  input  logic                             nReset,
  input  logic                             mag,
  input  logic                             idx,
  input  logic                             errClr,
  output logic [$clog2(NUM_SLICES)-1:0]    slice,
  output logic [$clog2(NUM_SLICES)-1:0]    sliceOpp,
  output logic                             sliceStrobe,
  output logic                             frameStart,
  output logic                             valid,
  output logic                             error,
  output logic [$clog2(TIMEOUT_CYC+1)-1:0] period
);

  localparam int SW   = $clog2(NUM_SLICES);
  localparam int MW   = $clog2(NUM_MAG);
  localparam int SPM  = NUM_SLICES / NUM_MAG;
  localparam int SPMW = $clog2(SPM);
  localparam int UW   = (SPMW > 0) ? SPMW : 1;
  localparam int CW   = $clog2(TIMEOUT_CYC + 1);
  localparam int LW   = $clog2(DEBOUNCE + 1);
  localparam int STW  = CW + FRAC_BITS;
  localparam int SH   = FRAC_BITS - SPMW;

  if (CLK_FREQ < 1 || NUM_MAG < 2 || (1 << MW) != NUM_MAG ||
      (1 << SW) != NUM_SLICES || SPM * NUM_MAG != NUM_SLICES ||
      SH < 0 || DEBOUNCE < 1) begin : g_bad_param
    $error("rotor_slice_timer: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE, MEASURE, WAIT_IDX, LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     magS_q, idxS_q;
  logic           magReg_q;
  logic [LW-1:0]  lock_q;
  logic           evt_q, evtIdx_q;
  logic           accept;
  logic [CW-1:0]  seg_q, seg_d, segInc;
  logic [CW-1:0]  period_q, period_d;
  logic [STW-1:0] step_q, step_d;
  logic [STW-1:0] acc_q, acc_d;
  logic [STW:0]   sum, stepEff, inc;
  logic [MW-1:0]  magIdx_q, magIdx_d;
  logic [UW-1:0]  sub_q, sub_d;
  logic [SW-1:0]  slice_q, slice_d;
  logic           strobe_q, frame_q, frame_d;
  logic           err_q, err_d, setErr;

  assign accept = (magS_q[1] != magReg_q) && (lock_q == '0);

  // Edge detect is registered so idx is captured with the accepted edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      magS_q   <= '0;
      idxS_q   <= '0;
      magReg_q <= 1'b0;
      lock_q   <= '0;
      evt_q    <= 1'b0;
      evtIdx_q <= 1'b0;
    end else begin
      magS_q   <= {magS_q[0], mag};
      idxS_q   <= {idxS_q[0], idx};
      evt_q    <= accept;
      evtIdx_q <= accept & idxS_q[1];
      if (accept) begin
        magReg_q <= magS_q[1];
        lock_q   <= LW'(DEBOUNCE - 1);
      end else if (lock_q != '0) begin
        lock_q <= lock_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    segInc   = (seg_q == CW'(TIMEOUT_CYC)) ? seg_q : seg_q + 1'b1;
    seg_d    = segInc;
    period_d = period_q;
    step_d   = step_q;
    acc_d    = acc_q;
    sub_d    = sub_q;
    magIdx_d = magIdx_q;
    slice_d  = slice_q;
    frame_d  = 1'b0;
    setErr   = 1'b0;
    inc      = '0;
    inc[FRAC_BITS] = 1'b1;
    stepEff  = (step_q == '0) ? inc : {1'b0, step_q};
    sum      = {1'b0, acc_q} + inc;

    // period counts the event cycle itself, so it equals the edge spacing
    if (evt_q) begin
      seg_d    = '0;
      period_d = segInc;
      step_d   = STW'(segInc) << SH;
    end

    unique case (state_q)
      IDLE: begin
        if (evt_q) state_d = MEASURE;
      end
      MEASURE: begin
        if (evt_q) state_d = WAIT_IDX;
      end
      WAIT_IDX: begin
        if (evt_q && evtIdx_q) begin
          state_d  = LOCKED;
          magIdx_d = '0;
          sub_d    = '0;
          acc_d    = '0;
          slice_d  = '0;
          frame_d  = 1'b1;
        end
      end
      LOCKED: begin
        if (evt_q) begin
          sub_d = '0;
          acc_d = '0;
          if (evtIdx_q) begin
            magIdx_d = '0;
            frame_d  = 1'b1;
            setErr   = (magIdx_q != MW'(NUM_MAG - 1));
          end else begin
            magIdx_d = magIdx_q + 1'b1;
          end
          slice_d = SW'(magIdx_d) << SPMW;
        end else begin
          acc_d = STW'(sum);
          if (sum >= stepEff) begin
            acc_d = STW'(sum - stepEff);
            if (sub_q != UW'(SPM - 1)) begin
              sub_d   = sub_q + 1'b1;
              slice_d = slice_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !evt_q && seg_q == CW'(TIMEOUT_CYC)) begin
      state_d  = IDLE;
      slice_d  = '0;
      sub_d    = '0;
      acc_d    = '0;
      magIdx_d = '0;
      setErr   = 1'b1;
    end

    err_d = err_q;
    if (setErr)      err_d = 1'b1;
    else if (errClr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      seg_q    <= '0;
      period_q <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      sub_q    <= '0;
      magIdx_q <= '0;
      slice_q  <= '0;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      period_q <= period_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      sub_q    <= sub_d;
      magIdx_q <= magIdx_d;
      slice_q  <= slice_d;
      strobe_q <= (slice_d != slice_q);
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign slice       = slice_q;
  assign sliceOpp    = slice_q + SW'(NUM_SLICES / 2);
  assign sliceStrobe = strobe_q;
  assign frameStart  = frame_q;
  assign valid       = (state_q == LOCKED);
  assign error       = err_q;
  assign period      = period_q;

endmodule

// File: tb/tb_rotor_slice_timer.sv
// Bench for rotor_slice_timer: directed magnet sequences with a
// time-stamped expectation queue checked on the falling clock edge.
module tb_rotor_slice_timer;

  localparam int SL = 0, OPP = 1, VAL = 2, ERR = 3;
  localparam int PER = 4, STRB = 5, FRM = 6;

  logic        clk, nReset, mag, idx, errClr;
  logic [3:0]  slice, sliceOpp;
  logic        sliceStrobe, frameStart, valid, error;
  logic [13:0] period;

  rotor_slice_timer #(
    .CLK_FREQ(50_000_000), .NUM_MAG(4), .NUM_SLICES(16),
    .FRAC_BITS(4), .DEBOUNCE(8), .TIMEOUT_CYC(10000)
  ) dut (
    .clk(clk), .nReset(nReset), .mag(mag), .idx(idx),
    .errClr(errClr), .slice(slice), .sliceOpp(sliceOpp),
    .sliceStrobe(sliceStrobe), .frameStart(frameStart),
    .valid(valid), .error(error), .period(period)
  );

  typedef struct packed { int cyc; int sel; int val; } exp_t;
  exp_t sb[$];

  int cyc = 0, nTot = 0, nBad = 0;
  int strbTot = 0, frmTot = 0;
  int mState = 0, mMag = 0, prevLen = 0, mErr = 0;
  int mStrb = 0, mFrm = 0, mSlice = 0, lastE = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string nm(int s);
    case (s)
      SL:      nm = "slice";
      OPP:     nm = "sliceOpp";
      VAL:     nm = "valid";
      ERR:     nm = "error";
      PER:     nm = "period";
      STRB:    nm = "strobeCount";
      FRM:     nm = "frameCount";
      default: nm = "unknown";
    endcase
  endfunction

  function automatic logic [31:0] observe(int s);
    case (s)
      SL:      observe = 32'(slice);
      OPP:     observe = 32'(sliceOpp);
      VAL:     observe = 32'(valid);
      ERR:     observe = 32'(error);
      PER:     observe = 32'(period);
      STRB:    observe = strbTot;
      FRM:     observe = frmTot;
      default: observe = 'x;
    endcase
  endfunction

  function automatic void push(int c, int s, int v);
    exp_t x;
    int i;
    x.cyc = c;
    x.sel = s;
    x.val = v;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, x);
  endfunction

  always @(negedge clk) begin
    if (sliceStrobe === 1'b1) strbTot++;
    if (frameStart === 1'b1) frmTot++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t x;
      logic [31:0] obs;
      x = sb.pop_front();
      obs = observe(x.sel);
      nTot++;
      assert (obs === 32'(x.val)) else begin
        nBad++;
        $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
               nm(x.sel), x.cyc, obs, x.val);
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exv);
    nTot++;
    assert (obs === exv) else begin
      nBad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exv);
    end
  endtask

  // One magnet segment of len cycles; expectations follow the event.
  task automatic segx(int len, bit withIdx, bit bounce, int clrAt);
    int e, stp, k;
    bit wasIdle;
    e = cyc + 4;
    lastE = e;
    wasIdle = (mState == 0);
    stp = prevLen * 4;
    case (mState)
      0: mState = 1;
      1: mState = 2;
      2: if (withIdx) begin
        mState = 3;
        mMag = 0;
        mFrm++;
      end
      default: begin
        if (withIdx) begin
          if (mMag != 3) mErr = 1;
          mMag = 0;
          mFrm++;
        end else begin
          mMag = (mMag + 1) % 4;
        end
      end
    endcase
    if (mState == 3) begin
      if (mMag * 4 != mSlice) mStrb++;
      mSlice = mMag * 4;
    end
    push(e, SL, mSlice);
    push(e, OPP, (mSlice + 8) % 16);
    push(e, VAL, (mState == 3) ? 1 : 0);
    push(e, ERR, mErr);
    push(e, STRB, mStrb);
    push(e, FRM, mFrm);
    if (!wasIdle) push(e, PER, prevLen);
    if (mState == 3) begin
      for (int j = 1; j <= 3; j++) begin
        k = (j * stp + 15) / 16;
        if (k < len) begin
          push(e + k - 1, SL, mSlice);
          mSlice++;
          mStrb++;
          push(e + k, SL, mSlice);
          push(e + k, STRB, mStrb);
        end
      end
      push(e + len - 1, SL, mSlice);
      push(e + len - 1, STRB, mStrb);
    end
    if (clrAt >= 0) begin
      mErr = 0;
      push(cyc + clrAt + 1, ERR, 0);
    end
    for (int c = 0; c < len; c++) begin
      if (c == 0) begin
        mag = ~mag;
        idx = withIdx;
      end
      if (bounce && (c == 3 || c == 5)) mag = ~mag;
      if (c == 20) idx = 1'b0;
      if (clrAt >= 0 && c == clrAt) errClr = 1'b1;
      if (clrAt >= 0 && c == clrAt + 1) errClr = 1'b0;
      @(posedge clk);
      #1;
    end
    prevLen = len;
  endtask

  task automatic seg(int len);
    segx(len, (mState == 3 && mMag == 3), 1'b0, -1);
  endtask

  task automatic stopTimeout();
    int t;
    t = lastE + 10000;
    push(t, VAL, 1);
    if (mSlice != 0) mStrb++;
    mSlice = 0;
    mErr = 1;
    mState = 0;
    push(t + 1, VAL, 0);
    push(t + 1, ERR, 1);
    push(t + 1, SL, 0);
    push(t + 1, OPP, 8);
    push(t + 1, STRB, mStrb);
    while (cyc < t + 5) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    nReset = 1'b0;
    mag = 1'b0;
    idx = 1'b0;
    errClr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, SL, 0);
    push(cyc, OPP, 8);
    push(cyc, VAL, 0);
    push(cyc, ERR, 0);
    push(cyc, PER, 0);
    push(cyc, STRB, 0);
    push(cyc, FRM, 0);
    @(posedge clk);
    #1;
    nReset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 13; i++) segx(400, (i % 4) == 0, 1'b0, -1);

    repeat (40) seg(403);

    seg(400);
    seg(800);
    seg(800);
    seg(400);
    seg(400);

    segx(400, (mState == 3 && mMag == 3), 1'b1, -1);
    seg(400);
    seg(400);

    for (int g = 0; g < 8 && mMag != 2; g++) seg(400);
    segx(400, 1'b1, 1'b0, 200);
    repeat (4) seg(400);

    stopTimeout();

    segx(400, 1'b0, 1'b0, -1);
    segx(400, 1'b0, 1'b0, -1);
    segx(400, 1'b1, 1'b0, -1);
    seg(400);
    seg(400);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("prereset_valid", 32'(valid), 1);
    chk("prereset_slice", 32'(slice), 11);
    nReset = 1'b0;
    #1;
    chk("rst_slice", 32'(slice), 0);
    chk("rst_sliceOpp", 32'(sliceOpp), 8);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_strobe", 32'(sliceStrobe), 0);
    chk("rst_frame", 32'(frameStart), 0);
    mag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nReset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      nTot++;
      nBad++;
      $error("FAIL pending_expectations observed=%0d expected=0",
             sb.size());
    end
    $display("test done: total=%0d bad=%0d", nTot, nBad);
    $finish;
  end

endmodule
